// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with an internal pixel-clock enable,
// one-pixel-ahead coordinates and a registered RGB332 -> RGB888 output stage.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int          XW      = $clog2(H_TOTAL),
    localparam int          YW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [7:0]    color_i,
    output logic          pix_ce_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          frame_start_o,
    output logic          line_start_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          blank_n_o,
    output logic [7:0]    r_o,
    output logic [7:0]    g_o,
    output logic [7:0]    b_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          pix_ce_q, pix_ce_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_n_q, blank_n_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;

    logic [31:0]   x_ext, y_ext;
    logic          vis, hs, vs;

    // Stage-0 decode; widened so window ends equal to the total never overflow.
    always_comb begin
        x_ext = 32'(x_q);
        y_ext = 32'(y_q);
        vis   = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
        hs    = (x_ext >= HS_START) && (x_ext < HS_END);
        vs    = (y_ext >= VS_START) && (y_ext < VS_END);
    end

    always_comb begin
        // NOTE: every _d gets a hold default first so no path can infer a latch.
        dcnt_d    = dcnt_q;
        pix_ce_d  = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;

        if (!en_i) begin
            dcnt_d    = '0;
            x_d       = '0;
            y_d       = '0;
            hsync_d   = ~HS_POL;
            vsync_d   = ~VS_POL;
            blank_n_d = 1'b0;
            r_d       = '0;
            g_d       = '0;
            b_d       = '0;
        end else begin
            // Registered enable: first pulse lands CLK_DIV clocks after en_i rises.
            dcnt_d   = (dcnt_q == DIV_LAST) ? '0 : dcnt_q + 1'b1;
            pix_ce_d = (dcnt_q == DIV_LAST);

            if (pix_ce_q) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end

                hsync_d   = hs ? HS_POL : ~HS_POL;
                vsync_d   = vs ? VS_POL : ~VS_POL;
                blank_n_d = vis;
                r_d       = vis ? {color_i[7:5], color_i[7:5], color_i[7:6]} : 8'h00;
                g_d       = vis ? {color_i[4:2], color_i[4:2], color_i[4:3]} : 8'h00;
                b_d       = vis ? {4{color_i[1:0]}} : 8'h00;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dcnt_q    <= '0;
            pix_ce_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            dcnt_q    <= dcnt_d;
            pix_ce_q  <= pix_ce_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign pix_ce_o      = pix_ce_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = pix_ce_q && (x_q == '0) && (y_q == '0);
    assign line_start_o  = pix_ce_q && (x_q == '0);
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign blank_n_o     = blank_n_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a tiny raster at
// CLK_DIV=1 and CLK_DIV=3, enable drop/restart and asynchronous reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Default geometry, CLK_DIV=2
    logic       d_en, d_pce, d_fs, d_ls, d_hs, d_vs, d_bn;
    logic [7:0] d_color, d_r, d_g, d_b;
    logic [9:0] d_x, d_y;

    // Tiny geometry (7 x 5), CLK_DIV=1
    logic       s_en, s_pce, s_fs, s_ls, s_hs, s_vs, s_bn;
    logic [7:0] s_color, s_r, s_g, s_b;
    logic [2:0] s_x, s_y;

    // Tiny geometry (7 x 5), CLK_DIV=3
    logic       t_en, t_pce, t_fs, t_ls, t_hs, t_vs, t_bn;
    logic [7:0] t_color, t_r, t_g, t_b;
    logic [2:0] t_x, t_y;

    vga_timing_gen u_def (
        .clk_i(clk), .rst_ni(rst_n), .en_i(d_en), .color_i(d_color),
        .pix_ce_o(d_pce), .x_o(d_x), .y_o(d_y),
        .frame_start_o(d_fs), .line_start_o(d_ls),
        .hsync_o(d_hs), .vsync_o(d_vs), .blank_n_o(d_bn),
        .r_o(d_r), .g_o(d_g), .b_o(d_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk_i(clk), .rst_ni(rst_n), .en_i(s_en), .color_i(s_color),
        .pix_ce_o(s_pce), .x_o(s_x), .y_o(s_y),
        .frame_start_o(s_fs), .line_start_o(s_ls),
        .hsync_o(s_hs), .vsync_o(s_vs), .blank_n_o(s_bn),
        .r_o(s_r), .g_o(s_g), .b_o(s_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_div3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(t_en), .color_i(t_color),
        .pix_ce_o(t_pce), .x_o(t_x), .y_o(t_y),
        .frame_start_o(t_fs), .line_start_o(t_ls),
        .hsync_o(t_hs), .vsync_o(t_vs), .blank_n_o(t_bn),
        .r_o(t_r), .g_o(t_g), .b_o(t_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] col_tbl [4] = '{8'hE0, 8'hA5, 8'h1C, 8'h03};
    logic [7:0] r_tbl   [4] = '{8'hFF, 8'hB6, 8'h00, 8'h00};
    logic [7:0] g_tbl   [4] = '{8'h00, 8'h24, 8'hFF, 8'h00};
    logic [7:0] b_tbl   [4] = '{8'h00, 8'h55, 8'h00, 8'hFF};

    initial begin
        rst_n   = 1'b0;
        d_en    = 1'b0; s_en = 1'b0; t_en = 1'b0;
        d_color = 8'h00; s_color = 8'h03; t_color = 8'hFF;

        // Reset state
        repeat (3) tick();
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_pce", d_pce, 0);
        check("rst_fs", d_fs, 0);
        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_blank", d_bn, 0);
        check("rst_rgb", {d_r, d_g, d_b}, 0);

        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_pce", d_pce, 0);
        check("idle_s_pce", s_pce, 0);

        // Tiny raster, CLK_DIV=1: pixel m is presented m clocks after the first pulse
        s_en = 1'b1;
        tick();
        check("s_first_pce", s_pce, 1);
        check("s_first_fs", s_fs, 1);
        check("s_first_x", s_x, 0);
        check("s_first_blank", s_bn, 0);
        for (int m = 1; m <= 36; m++) begin
            int qx, qy;
            tick();
            qx = (m - 1) % 7;
            qy = ((m - 1) / 7) % 5;
            check("s_x", s_x, m % 7);
            check("s_y", s_y, (m / 7) % 5);
            check("s_frame_start", s_fs, (m % 35 == 0) ? 1 : 0);
            check("s_line_start", s_ls, (m % 7 == 0) ? 1 : 0);
            check("s_hsync", s_hs, (qx == 5) ? 0 : 1);
            check("s_vsync", s_vs, (qy == 3) ? 0 : 1);
            check("s_blank_n", s_bn, (qx < 4 && qy < 2) ? 1 : 0);
            check("s_b", s_b, (qx < 4 && qy < 2) ? 8'hFF : 8'h00);
        end

        // Tiny raster, CLK_DIV=3: enable cadence and output hold between pulses
        t_en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            int p;
            tick();
            p = (j - 1) / 3 - 1;
            if (j <= 18) begin
                check("t_pce", t_pce, (j % 3 == 0) ? 1 : 0);
                check("t_x", t_x, (j - 1) / 3);
                check("t_blank_n", t_bn, (p >= 0 && p < 4) ? 1 : 0);
                check("t_r", t_r, (p >= 0 && p < 4) ? 8'hFF : 8'h00);
            end
            if (j == 3) check("t_first_fs", t_fs, 1);
        end
        check("t_drop_x", t_x, 2);
        check("t_drop_y", t_y, 1);
        check("t_drop_pce", t_pce, 1);
        check("t_drop_blank", t_bn, 1);

        // Mid-frame enable drop at (2,1), held 5 clocks, then restart
        t_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t_off_x", t_x, 0);
            check("t_off_y", t_y, 0);
            check("t_off_pce", t_pce, 0);
            check("t_off_blank", t_bn, 0);
            check("t_off_r", t_r, 0);
        end
        t_en = 1'b1;
        tick();
        check("t_re_pce1", t_pce, 0);
        tick();
        check("t_re_pce2", t_pce, 0);
        tick();
        check("t_re_pce3", t_pce, 1);
        check("t_re_fs", t_fs, 1);
        check("t_re_x", t_x, 0);
        check("t_re_y", t_y, 0);

        // Default 640x480 at CLK_DIV=2: first line timing and colour expansion
        d_color = col_tbl[0];
        d_en    = 1'b1;
        tick();
        check("d_pce_wait", d_pce, 0);
        tick();
        check("d_first_pce", d_pce, 1);
        check("d_first_fs", d_fs, 1);
        check("d_first_ls", d_ls, 1);
        check("d_first_xy", {d_x, d_y}, 0);
        check("d_first_blank", d_bn, 0);
        for (int k = 1; k <= 800; k++) begin
            repeat (2) tick();
            if (k <= 4) begin
                check("d_r", d_r, r_tbl[k-1]);
                check("d_g", d_g, g_tbl[k-1]);
                check("d_b", d_b, b_tbl[k-1]);
                check("d_blank_vis", d_bn, 1);
            end
            case (k)
                400: check("d_vsync_line0", d_vs, 1);
                640: begin
                    check("d_last_vis_r", d_r, 8'hFF);
                    check("d_last_vis_blank", d_bn, 1);
                end
                641: begin
                    check("d_porch_rgb", {d_r, d_g, d_b}, 0);
                    check("d_porch_blank", d_bn, 0);
                end
                656: check("d_hsync_656", d_hs, 1);
                657: check("d_hsync_657", d_hs, 0);
                752: check("d_hsync_752", d_hs, 0);
                753: check("d_hsync_753", d_hs, 1);
                799: check("d_x_last", d_x, 799);
                800: begin
                    check("d_wrap_x", d_x, 0);
                    check("d_wrap_y", d_y, 1);
                    check("d_wrap_ls", d_ls, 1);
                    check("d_wrap_fs", d_fs, 0);
                end
                default: ;
            endcase
            if (k < 4) d_color = col_tbl[k];
            else if (k == 640) d_color = 8'hFF;
            else d_color = 8'hE0;
        end

        // Into line 1 hsync, then asynchronous reset between clock edges
        repeat (1400) tick();
        check("d_pre_rst_x", d_x, 700);
        check("d_pre_rst_hsync", d_hs, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_x", d_x, 0);
        check("arst_y", d_y, 0);
        check("arst_pce", d_pce, 0);
        check("arst_ls", d_ls, 0);
        check("arst_hsync", d_hs, 1);
        check("arst_vsync", d_vs, 1);
        check("arst_rgb", {d_r, d_g, d_b}, 0);
        check("arst_s_x", s_x, 0);
        #10;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
